// File: rtl/data_stack_pkg.sv
// Shared definitions for the operand stack: default word width and depth,
// the decoded stack operation type, and the strobe decode helper.
package data_stack_pkg;

    localparam int unsigned WORD_W      = 16;
    localparam int unsigned STACK_DEPTH = 16;

    typedef enum logic [2:0] {
        OpHold,
        OpPush,
        OpPop,
        OpLoad,
        OpReplace
    } stack_op_e;

    // push and pop together is a net replace; load_stk alone is a plain register write.
    // A pop with load_stk set is still OpPop (binary op); the load is applied inside it.
    function automatic stack_op_e decode_op(logic push, logic pop, logic load_stk);
        if (push && pop) return OpReplace;
        if (push)        return OpPush;
        if (pop)         return OpPop;
        if (load_stk)    return OpLoad;
        return OpHold;
    endfunction

endpackage

// File: rtl/data_stack_if.sv
// Strobe and status bundle between the control unit and the operand stack.
//   master: drives pop/push/load_stk/wr_stk1/din/clr_err, observes stack state
//   slave : the stack itself
interface data_stack_if
    import data_stack_pkg::*;
#(
    parameter int unsigned DEPTH = STACK_DEPTH,
    parameter int unsigned WIDTH = WORD_W
);
    localparam int unsigned DW = $clog2(DEPTH + 1);

    logic             pop;
    logic             push;
    logic             load_stk;
    logic             wr_stk1;
    logic [WIDTH-1:0] din;
    logic             clr_err;
    logic [WIDTH-1:0] stk0;
    logic [WIDTH-1:0] stk1;
    logic [DW-1:0]    depth;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             udf;

    modport master (
        output pop, push, load_stk, wr_stk1, din, clr_err,
        input  stk0, stk1, depth, empty, full, ovf, udf
    );

    modport slave (
        input  pop, push, load_stk, wr_stk1, din, clr_err,
        output stk0, stk1, depth, empty, full, ovf, udf
    );

endinterface

// File: rtl/data_stack_ram.sv
// Spill storage for stack entries below stk0/stk1.
//   clk_i   : write clock
//   we_i    : write enable, waddr_i/wdata_i sampled on rising edge
//   raddr_i : asynchronous read address, rdata_o follows combinationally
// No reset: contents are don't-care until written.
module data_stack_ram #(
    parameter int unsigned Entries = 14,
    parameter int unsigned Width   = 16,
    parameter int unsigned Aw      = 4
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [Aw-1:0]    waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Aw-1:0]    raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Entries];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_stack.sv
// Operand stack for the stack CPU. stk0/stk1 live in registers and feed the ALU;
// deeper entries spill into data_stack_ram. Tracks depth and sticky ovf/udf flags.
//   clk, rst : clock, asynchronous active-high reset
//   bus_io   : strobes in (pop/push/load_stk/wr_stk1/din/clr_err),
//              state out (stk0/stk1/depth/empty/full/ovf/udf)
module data_stack
    import data_stack_pkg::*;
#(
    parameter int unsigned DEPTH = STACK_DEPTH,
    parameter int unsigned WIDTH = WORD_W
) (
    input logic         clk,
    input logic         rst,
    data_stack_if.slave bus_io
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned Entries = DEPTH - 2;
    localparam int unsigned AW = (Entries > 1) ? $clog2(Entries) : 1;

    logic [WIDTH-1:0] stk0_q, stk0_d;
    logic [WIDTH-1:0] stk1_q, stk1_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [AW-1:0]    ram_raddr;
    logic [WIDTH-1:0] ram_rdata;

    logic      is_empty, is_full, deep;
    stack_op_e op;

    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == DW'(DEPTH));
    assign deep     = (depth_q >= DW'(3));
    assign op       = decode_op(bus_io.push, bus_io.pop, bus_io.load_stk);

    // Entry just below stk1 sits at depth-3; held at 0 when shallow so the
    // array is never addressed out of range.
    assign ram_raddr = deep ? AW'(depth_q - DW'(3)) : '0;

    always_comb begin
        stk0_d    = stk0_q;
        stk1_d    = stk1_q;
        depth_d   = depth_q;
        ovf_d     = ovf_q & ~bus_io.clr_err;
        udf_d     = udf_q & ~bus_io.clr_err;
        ram_we    = 1'b0;
        ram_waddr = '0;

        unique case (op)
            OpPush: begin
                stk1_d = stk0_q;
                if (bus_io.load_stk) stk0_d = bus_io.din;
                if (is_full) begin
                    // Spill array is already full: the entry leaving stk1 is dropped.
                    ovf_d = 1'b1;
                end else begin
                    depth_d = depth_q + DW'(1);
                    if (depth_q >= DW'(2)) begin
                        ram_we    = 1'b1;
                        ram_waddr = AW'(depth_q - DW'(2));
                    end
                end
            end
            OpPop: begin
                if (is_empty) begin
                    stk0_d = bus_io.load_stk ? bus_io.din : '0;
                    stk1_d = '0;
                    udf_d  = 1'b1;
                end else begin
                    stk0_d  = bus_io.load_stk ? bus_io.din : stk1_q;
                    stk1_d  = deep ? ram_rdata : '0;
                    depth_d = depth_q - DW'(1);
                end
            end
            OpLoad: begin
                if (bus_io.wr_stk1) stk1_d = bus_io.din;
                else                stk0_d = bus_io.din;
            end
            OpReplace: begin
                if (bus_io.load_stk) stk0_d = bus_io.din;
            end
            OpHold: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stk0_q  <= '0;
            stk1_q  <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            stk0_q  <= stk0_d;
            stk1_q  <= stk1_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    data_stack_ram #(
        .Entries (Entries),
        .Width   (WIDTH),
        .Aw      (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (stk1_q),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign bus_io.stk0  = stk0_q;
    assign bus_io.stk1  = stk1_q;
    assign bus_io.depth = depth_q;
    assign bus_io.empty = is_empty;
    assign bus_io.full  = is_full;
    assign bus_io.ovf   = ovf_q;
    assign bus_io.udf   = udf_q;

endmodule
